// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: arbitrates two requesters for the hex display word
// and swaps the word only in the single cycle after the last pixel of a
// frame, so the decoded digits never tear mid-frame.
module lcd_frame_scheduler #(
    parameter int C_data_len = 128,
    parameter int C_width    = 240,
    parameter int C_height   = 240,
    parameter int C_cnt_bits = 16
) (
    input  logic                  clk,
    input  logic                  resn,
    input  logic [7:0]            x,
    input  logic [7:0]            y,
    input  logic                  next_pixel,
    input  logic                  req_a,
    input  logic [C_data_len-1:0] data_a,
    output logic                  ack_a,
    input  logic                  req_b,
    input  logic [C_data_len-1:0] data_b,
    output logic                  ack_b,
    output logic [C_data_len-1:0] display,
    output logic                  owner,
    output logic                  frame_start,
    output logic [C_cnt_bits-1:0] frame_count,
    output logic                  resync
);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    localparam logic [7:0] LAST_X = 8'(C_width - 1);
    localparam logic [7:0] LAST_Y = 8'(C_height - 1);

    state_t state, state_nxt;
    logic   first, last;
    logic   fs_nxt, rs_nxt;
    logic   grant_a, grant_b;

    // Frame boundary qualifiers; only meaningful while a pixel is fetched.
    assign first = next_pixel && (x == 8'd0)   && (y == 8'd0);
    assign last  = next_pixel && (x == LAST_X) && (y == LAST_Y);

    // Next-state, pulse and grant decode. Grants exist only in SWAP; on a
    // tie the requester that did not win last time gets the word.
    always_comb begin
        state_nxt = state;
        fs_nxt    = 1'b0;
        rs_nxt    = 1'b0;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (first) begin
                    state_nxt = SCAN;
                    fs_nxt    = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    state_nxt = SWAP;
                end else if (first) begin
                    // Raster restarted early: re-align, keep the word.
                    fs_nxt = 1'b1;
                    rs_nxt = 1'b1;
                end
            end
            SWAP: begin
                state_nxt = IDLE;
                grant_a   = req_a && (!req_b || owner);
                grant_b   = req_b && (!req_a || !owner);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Display word, ownership, pulses and frame counter.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            display     <= '0;
            owner       <= 1'b1;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            frame_start <= 1'b0;
            resync      <= 1'b0;
            frame_count <= '0;
        end else begin
            ack_a       <= grant_a;
            ack_b       <= grant_b;
            frame_start <= fs_nxt;
            resync      <= rs_nxt;
            if (grant_a) begin
                display <= data_a;
                owner   <= 1'b0;
            end else if (grant_b) begin
                display <= data_b;
                owner   <= 1'b1;
            end
            // A frame completes on every SWAP, granted or not.
            if (state == SWAP) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler. Stimulus pushes the expected
// output event (frame_start/resync/ack with display, owner, frame_count)
// whenever it issues the pixel that causes it; the monitor pops on every
// event the DUT shows. frame_count is narrowed to 8 bits so the wrap test
// fits in a short run.
module tb_lcd_frame_scheduler;

    localparam int DW = 128;
    localparam int CB = 8;

    typedef struct packed {
        logic          fs;
        logic          rs;
        logic          aa;
        logic          ab;
        logic [DW-1:0] disp;
        logic          own;
        logic [CB-1:0] fc;
    } ev_t;

    logic          clk = 1'b0;
    logic          resn = 1'b0;
    logic [7:0]    x = '0, y = '0;
    logic          next_pixel = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          ack_a, ack_b, owner, frame_start, resync;
    logic [DW-1:0] display;
    logic [CB-1:0] frame_count;

    ev_t q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Expected visible state, updated by hand in the test body/tasks.
    logic [DW-1:0] e_disp = '0;
    logic          e_own  = 1'b1;
    logic [CB-1:0] e_fc   = '0;

    lcd_frame_scheduler #(.C_data_len(DW), .C_width(240), .C_height(240),
                          .C_cnt_bits(CB)) dut (
        .clk(clk), .resn(resn), .x(x), .y(y), .next_pixel(next_pixel),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .display(display), .owner(owner), .frame_start(frame_start),
        .frame_count(frame_count), .resync(resync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every visible pulse must match the head of the queue.
    always @(negedge clk) begin
        if (resn && (ack_a || ack_b || frame_start || resync)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_event: got fs=%b rs=%b aa=%b ab=%b expected none",
                         frame_start, resync, ack_a, ack_b);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_pulses", {frame_start, resync, ack_a, ack_b}, {e.fs, e.rs, e.aa, e.ab});
                chk("ev_display", display, e.disp);
                chk("ev_owner", owner, e.own);
                chk("ev_frame_count", frame_count, e.fc);
            end
        end
    end

    // Apply one cycle of pixel inputs; returns #1 after the sampling edge.
    task automatic px(input int px_x, input int px_y, input logic np);
        x = px_x[7:0];
        y = px_y[7:0];
        next_pixel = np;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic fs, input logic rs, input logic aa,
                        input logic ab, input logic [DW-1:0] d,
                        input logic o, input logic [CB-1:0] f);
        ev_t e;
        e = '{fs: fs, rs: rs, aa: aa, ab: ab, disp: d, own: o, fc: f};
        q.push_back(e);
    endtask

    // Short frame: first pixel, one interior pixel, last pixel, SWAP cycle,
    // gap. who: 0 = no grant expected, 1 = A, 2 = B.
    task automatic frame(input int who, input logic [DW-1:0] nd, input logic no);
        push(1'b1, 1'b0, 1'b0, 1'b0, e_disp, e_own, e_fc);
        px(0, 0, 1'b1);
        px(17, 9, 1'b1);
        px(239, 239, 1'b1);
        e_fc = e_fc + 1'b1;
        if (who != 0) begin
            e_disp = nd;
            e_own  = no;
            push(1'b0, 1'b0, who == 1, who == 2, e_disp, e_own, e_fc);
        end
        px(0, 0, 1'b0);   // SWAP cycle, next_pixel low (gap)
        px(0, 0, 1'b0);
    endtask

    initial begin
        // Reset state.
        px(0, 0, 1'b0);
        chk("rst_display", display, '0);
        chk("rst_owner", owner, 1'b1);
        chk("rst_frame_count", frame_count, '0);
        chk("rst_pulses", {frame_start, resync, ack_a, ack_b}, 4'b0000);
        resn = 1'b1;
        px(0, 0, 1'b0);

        // 1: one full 240x240 raster, no requests.
        push(1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b1, 8'd0);
        for (int p = 0; p < 240 * 240; p++) px(p % 240, p / 240, 1'b1);
        px(0, 0, 1'b0);
        px(0, 0, 1'b0);
        e_fc = 8'd1;
        chk("t1_frame_count", frame_count, 8'd1);
        chk("t1_display", display, 128'h0);

        // 2: A requests mid-frame; display holds until after last.
        push(1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b1, 8'd1);
        px(0, 0, 1'b1);
        px(10, 0, 1'b1);
        data_a = 128'h1234;
        req_a  = 1'b1;
        px(11, 0, 1'b1);
        px(12, 0, 1'b1);
        chk("t2_display_held", display, 128'h0);
        px(239, 239, 1'b1);
        chk("t2_display_before_swap", display, 128'h0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 128'h1234, 1'b0, 8'd2);
        px(0, 0, 1'b0);
        chk("t2_display_after", display, 128'h1234);
        req_a = 1'b0;
        px(0, 0, 1'b0);
        e_disp = 128'h1234; e_own = 1'b0; e_fc = 8'd2;

        // 3: both requesting for 3 frames -> B, A, B.
        data_b = 128'hBEEF_0000_CAFE;
        req_a = 1'b1;
        req_b = 1'b1;
        frame(2, 128'hBEEF_0000_CAFE, 1'b1);
        frame(1, 128'h1234, 1'b0);
        frame(2, 128'hBEEF_0000_CAFE, 1'b1);
        req_a = 1'b0;
        req_b = 1'b0;
        chk("t3_frame_count", frame_count, 8'd5);

        // 4: B raised then withdrawn before last -> no ack.
        push(1'b1, 1'b0, 1'b0, 1'b0, 128'hBEEF_0000_CAFE, 1'b1, 8'd5);
        data_b = 128'h5555;
        px(0, 0, 1'b1);
        req_b = 1'b1;
        px(1, 0, 1'b1);
        px(2, 0, 1'b1);
        req_b = 1'b0;
        px(3, 0, 1'b1);
        px(239, 239, 1'b1);
        px(0, 0, 1'b0);
        px(0, 0, 1'b0);
        chk("t4_display", display, 128'hBEEF_0000_CAFE);
        chk("t4_frame_count", frame_count, 8'd6);
        e_fc = 8'd6;

        // 5: (0,0) injected at pixel 1000 of SCAN -> resync, no swap.
        push(1'b1, 1'b0, 1'b0, 1'b0, 128'hBEEF_0000_CAFE, 1'b1, 8'd6);
        for (int p = 0; p < 1000; p++) px(p % 240, p / 240, 1'b1);
        push(1'b1, 1'b1, 1'b0, 1'b0, 128'hBEEF_0000_CAFE, 1'b1, 8'd6);
        px(0, 0, 1'b1);
        px(1, 0, 1'b1);
        chk("t5_frame_count_unchanged", frame_count, 8'd6);
        px(239, 239, 1'b1);
        px(0, 0, 1'b0);
        px(0, 0, 1'b0);
        chk("t5_frame_count_after", frame_count, 8'd7);

        // 6: reset mid-SCAN with A pending, then a full frame grants A.
        data_a = 128'hA5A5;
        req_a  = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 128'hBEEF_0000_CAFE, 1'b1, 8'd7);
        px(0, 0, 1'b1);
        px(1, 0, 1'b1);
        resn = 1'b0;
        #1;
        chk("t6_rst_display", display, 128'h0);
        chk("t6_rst_owner", owner, 1'b1);
        chk("t6_rst_frame_count", frame_count, 8'd0);
        px(2, 0, 1'b1);
        resn = 1'b1;
        px(239, 239, 1'b1);   // IDLE after reset: last is ignored
        px(0, 0, 1'b0);
        chk("t6_no_swap_before_first", frame_count, 8'd0);
        e_disp = 128'h0; e_own = 1'b1; e_fc = 8'd0;
        frame(1, 128'hA5A5, 1'b0);
        req_a = 1'b0;
        chk("t6_frame_count", frame_count, 8'd1);

        // frame_count wrap: run up to all-ones, then one more frame.
        for (int i = 0; i < 254; i++) frame(0, '0, 1'b0);
        chk("wrap_preload", frame_count, 8'hFF);
        frame(0, '0, 1'b0);
        chk("wrap_to_zero", frame_count, 8'h00);
        chk("wrap_display_kept", display, 128'hA5A5);

        px(0, 0, 1'b0);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // ack_a and ack_b must never be high together.
    always @(negedge clk) begin
        if (ack_a && ack_b) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_exclusive: got both high expected at most one");
        end
    end

endmodule
